rst_seq_gen: RTL and testbench
==============================

Name: rst_seq_gen

Overview:
- Parametrised successor to the single-pair reset/clock generator.
- Drives NUM_CH active-low reset outputs and a divided clock-enable from one clock, instead of derived clocks.
- Resets assert together; release is staged, channel 0 first, with a programmable gap between channels.
- Accepts a debounced external request and a synchronous software request; sits at the top level and feeds every core/SRAM/peripheral reset.

Parameters:
- NUM_CH, 2, number of reset channels (>=1).
- STRETCH, 16, cycles the request must stay inactive before channel 0 releases (>=1).
- GAP, 4, cycles between consecutive channel releases (>=1).
- FILT, 3, consecutive synchronised-low samples needed to accept an external request (>=1).
- DIV, 2, clock-enable divide ratio (>=1).

Ports:
- clk_100m  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- rst_req_n  in  1  asynchronous external reset request, active-low
- sw_rst  in  1  synchronous software reset request, active-high, level or pulse
- rst_ch_n  out  NUM_CH  registered per-channel resets, active-low
- seq_busy  out  1  high while any channel is held in reset
- ce_div  out  1  one-cycle enable every DIV cycles

Behaviour:
- rst=1 (async): rst_ch_n=0, seq_busy=1, ce_div=0, state=HOLD, cnt=0, idx=0, sync flops=0, filter count=0, req_f=1.
- rst_req_n passes through a 2-flop synchroniser (sync2).
- Filter: sync2=1 clears req_f immediately. sync2=0 for FILT consecutive cycles sets req_f. Each sync2=1 sample resets the filter count.
- req = req_f | sw_rst.
- State HOLD:
  - Outputs all 0.
  - If req, cnt<=0.
  - Else if cnt==STRETCH-1: go to RELEASE, rst_ch_n[0]<=1, cnt<=0.
  - Else cnt++.
  - If NUM_CH==1, the release goes directly to RUN with seq_busy<=0 on the same edge.
- State RELEASE:
  - If req: go to HOLD; all rst_ch_n<=0 on the next edge; cnt<=0; idx<=0.
  - Else if cnt==GAP-1: idx++, rst_ch_n[idx+1]<=1, cnt<=0. If that release is for channel NUM_CH-1, go to RUN and seq_busy<=0 on the same edge.
  - Else cnt++.
- State RUN:
  - All rst_ch_n=1, seq_busy=0.
  - req: go to HOLD; all rst_ch_n<=0 and seq_busy<=1 on the next edge (one cycle after req is seen).
- Released channels stay released until the next HOLD entry.
- Assertion is simultaneous on all channels, never staged.
- sw_rst and req_f together: treated as one request, no double action.
- rst mid-sequence restarts everything from the reset values.
- cnt width: $clog2(max(STRETCH,GAP)+1). Filter count width: $clog2(FILT+1). Counters saturate, never wrap.
- ce_div:
  - Divider counter 0..DIV-1, reset 0. ce_div=1 when counter==DIV-1 (registered).
  - DIV==1: ce_div=1 every cycle after reset.
  - Free-running; unaffected by the sequencer.

Optional Feature:
- Macro RST_SEQ_CAUSE_EN.
- Defined: adds output rst_cause[1:0], registered, holding the cause of the most recent HOLD entry.
  - 2'b00 = power-on (reset value).
  - 2'b01 = external request.
  - 2'b10 = software request.
  - 2'b11 = both seen in the same cycle.
  - Updated only on the HOLD-entry edge.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package rst_seq_pkg:
  - state enum (HOLD, RELEASE, RUN);
  - cause encoding constants;
  - width helper function for the counters.
- One natural sub-module: rst_req_filt (2-flop synchroniser plus FILT debounce, output req_f). The sequencer and divider stay in the top module.

Test Plan:
- Power-on with defaults, rst_req_n=1, sw_rst=0, rst released before edge 1 -> rst_ch_n[0] rises on edge 18, rst_ch_n[1] rises on edge 22, seq_busy falls on edge 22.
- In RUN, rst_req_n low for 2 cycles -> no reset. Low for 3+ cycles -> both rst_ch_n fall together 1 cycle after req_f rises; sequence restarts on deassertion.
- In RUN, sw_rst pulsed 1 cycle -> all channels low on next edge; ch0 releases 16 cycles later, ch1 4 cycles after that.
- sw_rst pulsed 2 cycles after ch0 releases (mid-RELEASE) -> ch0 re-asserts next edge, ch1 never released, full 16+4 sequence repeats.
- DIV=4 -> ce_div high exactly every 4th cycle (edges 4,8,12...) regardless of resets. DIV=1 -> constantly 1.
- RST_SEQ_CAUSE_EN with NUM_CH=3 -> rst_cause=00 after power-on, 01 after external request, 10 after sw_rst, 11 when both arrive in the same cycle; channels release in order 0,1,2.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
// Shared definitions for the staged reset sequencer:
//   - seq_state_t : sequencer states (HOLD, RELEASE, RUN)
//   - CAUSE_*     : encoding of the rst_cause output (RST_SEQ_CAUSE_EN builds)
//   - cnt_width() : width needed for a counter that must reach max_val
// -----------------------------------------------------------------------------
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_t;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_EXT  = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;
    localparam logic [1:0] CAUSE_BOTH = 2'b11;

    // Bits needed to hold values 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rst_seq_gen_req_filt.sv
// -----------------------------------------------------------------------------
// rst_req_filt
// Two-flop synchroniser plus debounce for the asynchronous, active-low external
// reset request. A request is accepted once the synchronised line has been low
// for FILT consecutive samples; a single high sample drops it again.
//
// Ports:
//   i_clk    : clock
//   i_rst    : asynchronous active-high reset (request is held active out of it)
//   i_req_n  : raw external request, active-low, asynchronous
//   o_req_f  : filtered request, active-high
// -----------------------------------------------------------------------------
module rst_req_filt
    import rst_seq_pkg::*;
#(
    parameter int FILT = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_n,
    output logic o_req_f
);

    localparam int             FW       = cnt_width(FILT);
    localparam logic [FW-1:0]  FILT_MAX = FW'(FILT);

    logic          r_sync1;
    logic          r_sync2;
    logic [FW-1:0] r_fcnt;
    logic          r_req_f;
    logic          w_run_ok;
    logic          w_req_f;

    // r_fcnt holds the low samples already seen; together with a low value
    // currently on r_sync2 that makes FILT in a row. Deciding on the current
    // r_sync2 value (rather than one sample later) lets both edges of the
    // synchronised request take effect in the cycle they appear on sync2.
    assign w_run_ok = (r_fcnt >= (FILT_MAX - 1'b1));
    assign w_req_f  = ~r_sync2 & (r_req_f | w_run_ok);
    assign o_req_f  = w_req_f;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_fcnt  <= '0;
            r_req_f <= 1'b1;
        end else begin
            r_sync1 <= i_req_n;
            r_sync2 <= r_sync1;
            r_req_f <= w_req_f;
            if (r_sync2) begin
                r_fcnt <= '0;
            end else if (r_fcnt != FILT_MAX) begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rst_seq_gen.sv
// -----------------------------------------------------------------------------
// rst_seq_gen
// Staged reset sequencer and clock-enable divider. All channel resets assert
// together on any request; release is staged channel 0 first, STRETCH quiet
// cycles after the request ends, then one channel every GAP cycles.
// A free-running divider produces a one-cycle enable every DIV cycles.
//
// Optional feature (macro RST_SEQ_CAUSE_EN): adds rst_cause[1:0], the cause of
// the most recent HOLD entry (00 power-on, 01 external, 10 software, 11 both).
//
// Ports:
//   clk_100m  : sole clock
//   rst       : asynchronous active-high reset
//   rst_req_n : asynchronous external reset request, active-low
//   sw_rst    : synchronous software reset request, active-high
//   rst_ch_n  : registered per-channel resets, active-low
//   seq_busy  : high while any channel is held in reset
//   ce_div    : one-cycle enable every DIV cycles
//   rst_cause : (RST_SEQ_CAUSE_EN only) cause of the last HOLD entry
// -----------------------------------------------------------------------------
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int STRETCH = 16,
    parameter int GAP     = 4,
    parameter int FILT    = 3,
    parameter int DIV     = 2
) (
    input  logic              clk_100m,
    input  logic              rst,
    input  logic              rst_req_n,
    input  logic              sw_rst,
    output logic [NUM_CH-1:0] rst_ch_n,
    output logic              seq_busy,
    output logic              ce_div
`ifdef RST_SEQ_CAUSE_EN
    ,
    output logic [1:0]        rst_cause
`endif
);

    localparam int            CW           = cnt_width((STRETCH > GAP) ? STRETCH : GAP);
    localparam int            IW           = cnt_width(NUM_CH - 1);
    localparam int            DW           = cnt_width(DIV - 1);
    localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(GAP - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_CH - 1);
    localparam logic [DW-1:0] DIV_LAST     = DW'(DIV - 1);

    seq_state_t        r_state, w_state;
    logic [CW-1:0]     r_cnt, w_cnt;
    logic [IW-1:0]     r_idx, w_idx;
    logic [NUM_CH-1:0] r_rst_ch_n, w_rst_ch_n;
    logic              r_seq_busy, w_seq_busy;
    logic [DW-1:0]     r_div_cnt;
    logic              r_ce_div;
    logic              w_req_f;
    logic              w_req;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    rst_req_filt #(
        .FILT (FILT)
    ) u_filt (
        .i_clk   (clk_100m),
        .i_rst   (rst),
        .i_req_n (rst_req_n),
        .o_req_f (w_req_f)
    );

    // External and software requests merge into one; both at once is one action.
    assign w_req = w_req_f | sw_rst;

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            r_state    <= HOLD;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_rst_ch_n <= '0;
            r_seq_busy <= 1'b1;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_idx      <= w_idx;
            r_rst_ch_n <= w_rst_ch_n;
            r_seq_busy <= w_seq_busy;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_idx      = r_idx;
        w_rst_ch_n = r_rst_ch_n;
        w_seq_busy = r_seq_busy;
        case (r_state)
            HOLD: begin
                w_rst_ch_n = '0;
                w_seq_busy = 1'b1;
                if (w_req) begin
                    w_cnt = '0;
                end else if (r_cnt == STRETCH_LAST) begin
                    w_cnt         = '0;
                    w_idx         = '0;
                    w_rst_ch_n[0] = 1'b1;
                    if (NUM_CH == 1) begin
                        w_state    = RUN;
                        w_seq_busy = 1'b0;
                    end else begin
                        w_state = RELEASE;
                    end
                end else begin
                    w_cnt = sat_inc(r_cnt);
                end
            end
            RELEASE: begin
                if (w_req) begin
                    w_state    = HOLD;
                    w_rst_ch_n = '0;
                    w_seq_busy = 1'b1;
                    w_cnt      = '0;
                    w_idx      = '0;
                end else if (r_cnt == GAP_LAST) begin
                    w_cnt = '0;
                    w_idx = r_idx + 1'b1;
                    // Earlier channels keep their released value; only the
                    // newly indexed one is raised.
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (c == int'(w_idx)) begin
                            w_rst_ch_n[c] = 1'b1;
                        end
                    end
                    if (w_idx == IDX_LAST) begin
                        w_state    = RUN;
                        w_seq_busy = 1'b0;
                    end
                end else begin
                    w_cnt = sat_inc(r_cnt);
                end
            end
            RUN: begin
                w_rst_ch_n = '1;
                w_seq_busy = 1'b0;
                if (w_req) begin
                    w_state    = HOLD;
                    w_rst_ch_n = '0;
                    w_seq_busy = 1'b1;
                    w_cnt      = '0;
                    w_idx      = '0;
                end
            end
            default: begin
                w_state    = HOLD;
                w_rst_ch_n = '0;
                w_seq_busy = 1'b1;
                w_cnt      = '0;
                w_idx      = '0;
            end
        endcase
    end

    // Free-running divider; ce_div is registered off the terminal count.
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_ce_div  <= 1'b0;
        end else begin
            r_ce_div  <= (r_div_cnt == DIV_LAST);
            r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
        end
    end

    assign rst_ch_n = r_rst_ch_n;
    assign seq_busy = r_seq_busy;
    assign ce_div   = r_ce_div;

`ifdef RST_SEQ_CAUSE_EN
    logic [1:0] r_cause;
    logic       w_hold_entry;

    // Staying in HOLD under a request is not an entry; only leaving
    // RELEASE/RUN for HOLD records a cause.
    assign w_hold_entry = (r_state != HOLD) && w_req;

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            r_cause <= CAUSE_POR;
        end else if (w_hold_entry) begin
            r_cause <= sw_rst ? (w_req_f ? CAUSE_BOTH : CAUSE_SW) : CAUSE_EXT;
        end
    end

    assign rst_cause = r_cause;
`endif

endmodule

// File: tb/tb_rst_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_gen
// Three sequencers with different parameter sets share one set of stimulus.
// The reference model tracks, per instance, the number of request-free edges
// since the last request (or reset); channel c is released once that count
// reaches STRETCH + c*GAP. The external request model delays the raw input by
// two edges and accepts it after FILT consecutive low samples.
// Optional macro RST_SEQ_CAUSE_EN also checks rst_cause.
// -----------------------------------------------------------------------------
module tb_rst_seq_gen;

    localparam int A_NCH = 2, A_STR = 16, A_GAP = 4, A_FILT = 3, A_DIV = 2;
    localparam int B_NCH = 3, B_STR = 5,  B_GAP = 2, B_FILT = 2, B_DIV = 4;
    localparam int C_NCH = 1, C_STR = 1,  C_GAP = 1, C_FILT = 1, C_DIV = 1;

    logic clk_100m = 1'b0;
    logic rst;
    logic rst_req_n;
    logic sw_rst;

    logic [A_NCH-1:0] ch_a;
    logic [B_NCH-1:0] ch_b;
    logic [C_NCH-1:0] ch_c;
    logic busy_a, busy_b, busy_c;
    logic ce_a, ce_b, ce_c;
`ifdef RST_SEQ_CAUSE_EN
    logic [1:0] cause_a, cause_b, cause_c;
`endif

    // Clock / reset
    always #5 clk_100m = ~clk_100m;

    rst_seq_gen #(.NUM_CH(A_NCH), .STRETCH(A_STR), .GAP(A_GAP), .FILT(A_FILT), .DIV(A_DIV)) dut_a (
        .clk_100m (clk_100m), .rst (rst), .rst_req_n (rst_req_n), .sw_rst (sw_rst),
        .rst_ch_n (ch_a), .seq_busy (busy_a), .ce_div (ce_a)
`ifdef RST_SEQ_CAUSE_EN
        , .rst_cause (cause_a)
`endif
    );

    rst_seq_gen #(.NUM_CH(B_NCH), .STRETCH(B_STR), .GAP(B_GAP), .FILT(B_FILT), .DIV(B_DIV)) dut_b (
        .clk_100m (clk_100m), .rst (rst), .rst_req_n (rst_req_n), .sw_rst (sw_rst),
        .rst_ch_n (ch_b), .seq_busy (busy_b), .ce_div (ce_b)
`ifdef RST_SEQ_CAUSE_EN
        , .rst_cause (cause_b)
`endif
    );

    rst_seq_gen #(.NUM_CH(C_NCH), .STRETCH(C_STR), .GAP(C_GAP), .FILT(C_FILT), .DIV(C_DIV)) dut_c (
        .clk_100m (clk_100m), .rst (rst), .rst_req_n (rst_req_n), .sw_rst (sw_rst),
        .rst_ch_n (ch_c), .seq_busy (busy_c), .ce_div (ce_c)
`ifdef RST_SEQ_CAUSE_EN
        , .rst_cause (cause_c)
`endif
    );

    // Reference model state
    int         p_nch[3], p_str[3], p_gap[3], p_filt[3], p_div[3];
    int         m_n[3];
    logic [1:0] m_cause[3];
    int         m_edge;
    logic       a_q[$];
    bit         m_seen_high;
    int         m_zrun;

    int checks;
    int failures;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, m_edge, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_ch(input int d);
        logic [7:0] v;
        v = '0;
        for (int c = 0; c < p_nch[d]; c++) begin
            if (m_n[d] >= p_str[d] + c * p_gap[d]) v[c] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [7:0] exp_busy(input int d);
        return (m_n[d] >= p_str[d] + (p_nch[d] - 1) * p_gap[d]) ? 8'd0 : 8'd1;
    endfunction

    function automatic logic [7:0] exp_ce(input int d);
        return (m_edge > 0 && (m_edge % p_div[d]) == 0) ? 8'd1 : 8'd0;
    endfunction

    task automatic model_reset();
        m_edge      = 0;
        m_seen_high = 1'b0;
        m_zrun      = 0;
        a_q.delete();
        a_q.push_back(1'b0);
        a_q.push_back(1'b0);
        for (int d = 0; d < 3; d++) begin
            m_n[d]     = 0;
            m_cause[d] = 2'b00;
        end
    endtask

    // One clock edge with raw request a and software request sw held across it.
    task automatic model_edge(input logic a, input logic sw);
        logic s;
        logic rf;
        s = a_q.pop_front();
        a_q.push_back(a);
        m_edge++;
        for (int d = 0; d < 3; d++) begin
            rf = !s && (!m_seen_high || (m_zrun + 1 >= p_filt[d]));
            if (rf || sw) begin
                if (m_n[d] >= p_str[d]) m_cause[d] = {sw, rf};
                m_n[d] = 0;
            end else begin
                m_n[d]++;
            end
        end
        if (s) begin
            m_seen_high = 1'b1;
            m_zrun      = 0;
        end else begin
            m_zrun++;
        end
    endtask

    task automatic check_all();
        chk("a_rst_ch_n", 8'(ch_a), exp_ch(0));
        chk("a_seq_busy", 8'(busy_a), exp_busy(0));
        chk("a_ce_div", 8'(ce_a), exp_ce(0));
        chk("b_rst_ch_n", 8'(ch_b), exp_ch(1));
        chk("b_seq_busy", 8'(busy_b), exp_busy(1));
        chk("b_ce_div", 8'(ce_b), exp_ce(1));
        chk("c_rst_ch_n", 8'(ch_c), exp_ch(2));
        chk("c_seq_busy", 8'(busy_c), exp_busy(2));
        chk("c_ce_div", 8'(ce_c), exp_ce(2));
`ifdef RST_SEQ_CAUSE_EN
        chk("a_rst_cause", 8'(cause_a), 8'(m_cause[0]));
        chk("b_rst_cause", 8'(cause_b), 8'(m_cause[1]));
        chk("c_rst_cause", 8'(cause_c), 8'(m_cause[2]));
`endif
    endtask

    // Driver: called at a falling edge; drives inputs for the next rising edge.
    task automatic step(input logic a, input logic sw);
        rst_req_n = a;
        sw_rst    = sw;
        @(posedge clk_100m);
        model_edge(a, sw);
        @(negedge clk_100m);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk_100m);
        @(negedge clk_100m);
        check_all();
        rst = 1'b0;
    endtask

    int   r0_edge, r1_edge, bf_edge;
    int   burst;
    logic a_v, sw_v;

    initial begin
        p_nch  = '{A_NCH, B_NCH, C_NCH};
        p_str  = '{A_STR, B_STR, C_STR};
        p_gap  = '{A_GAP, B_GAP, C_GAP};
        p_filt = '{A_FILT, B_FILT, C_FILT};
        p_div  = '{A_DIV, B_DIV, C_DIV};
        checks   = 0;
        failures = 0;
        rst_req_n = 1'b1;
        sw_rst    = 1'b0;

        // Power-on: reset released before the first rising edge.
        do_reset();
        r0_edge = -1; r1_edge = -1; bf_edge = -1;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0);
            if (r0_edge < 0 && ch_a[0] === 1'b1) r0_edge = m_edge;
            if (r1_edge < 0 && ch_a[1] === 1'b1) r1_edge = m_edge;
            if (bf_edge < 0 && busy_a === 1'b0) bf_edge = m_edge;
        end
        chk("por_ch0_release_edge", 8'(r0_edge), 8'd18);
        chk("por_ch1_release_edge", 8'(r1_edge), 8'd22);
        chk("por_busy_fall_edge", 8'(bf_edge), 8'd22);

        // External request shorter than the filter, then long enough.
        repeat (2) step(1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        repeat (40) step(1'b1, 1'b0);

        // Single-cycle software request from RUN.
        step(1'b1, 1'b1);
        repeat (30) step(1'b1, 1'b0);

        // Software request two cycles after channel 0 releases.
        step(1'b1, 1'b1);
        repeat (17) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (30) step(1'b1, 1'b0);

        // Level software request, then reset in the middle of a sequence.
        repeat (3) step(1'b1, 1'b1);
        repeat (10) step(1'b1, 1'b0);
        do_reset();
        repeat (30) step(1'b1, 1'b0);

        // External request accepted on the same edge as a software request.
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (30) step(1'b1, 1'b0);

        // Randomized traffic.
        burst = 0;
        for (int i = 0; i < 700; i++) begin
            if (burst == 0 && $urandom_range(0, 29) == 0) burst = $urandom_range(1, 6);
            a_v = (burst == 0);
            if (burst > 0) burst--;
            sw_v = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            step(a_v, sw_v);
        end
        repeat (30) step(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
